// File: rtl/alu_pkg.sv
// Shared opcode, state and flag helpers for the sequential ALU and its multiplier.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // For subtraction the effective B sign is inverted before applying the add rule.
  function automatic logic addsub_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bus between the register file, the sequential ALU and the result bus.
interface seq_alu_if #(parameter int WIDTH = 5);

  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [2:0]       S;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] P_hi;
  logic             Cout;
  logic             Overflow;
  logic             Zero;

  modport master (
    output start, X, Y, S,
    input  busy, done, F, P_hi, Cout, Overflow, Zero
  );

  modport slave (
    input  start, X, Y, S,
    output busy, done, F, P_hi, Cout, Overflow, Zero
  );

endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH iterations.
module seq_alu_mul #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               run,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_BITS = $clog2(WIDTH + 1);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_step;

  // The carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
  end

  assign run     = run_q;
  assign last    = run_q && (cnt_q == LAST_CNT);
  // Accumulator value after this cycle's step; the full product when last is high.
  assign product = acc_step;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (load) begin
      mcand_d = X;
      mplr_d  = Y;
      acc_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      acc_d  = acc_step;
      mplr_d = mplr_q >> 1;
      cnt_d  = cnt_q + CNT_BITS'(1);
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/busy/done handshake, registered result/flags and multi-cycle MUL.
//   state   | meaning
//   IDLE    | waiting for start; single-cycle ops computed on the accepting edge
//   MUL     | shift-add multiplier iterating
//   DONE    | done pulse, result valid; start ignored
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  state_e state_q, state_d;

  logic               accept, mul_load, mul_run, mul_last;
  logic               busy, done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] f_q, f_d, phi_q, phi_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] op_f;
  logic             op_cout, op_ovf;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .X       (bus.X),
    .Y       (bus.Y),
    .run     (mul_run),
    .last    (mul_last),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = (bus.S == OP_MUL) ? ST_MUL : ST_DONE;
      // A multiplier that is not running here can only mean a lost load; fall back to IDLE.
      ST_MUL:  if (mul_last) state_d = ST_DONE;
               else if (!mul_run) state_d = ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    accept   = (state_q == ST_IDLE) && bus.start;
    mul_load = accept && (bus.S == OP_MUL);
  end

  always_comb begin
    sum     = {1'b0, bus.X} + {1'b0, bus.Y};
    diff    = {1'b0, bus.X} - {1'b0, bus.Y};
    op_f    = '0;
    op_cout = 1'b0;
    op_ovf  = 1'b0;
    case (bus.S)
      OP_ADD: begin
        op_f    = sum[WIDTH-1:0];
        op_cout = sum[WIDTH];
        op_ovf  = addsub_ovf(bus.X[WIDTH-1], bus.Y[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        op_f    = diff[WIDTH-1:0];
        op_cout = ~diff[WIDTH];
        op_ovf  = addsub_ovf(bus.X[WIDTH-1], bus.Y[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OP_AND: op_f = bus.X & bus.Y;
      OP_OR:  op_f = bus.X | bus.Y;
      OP_XOR: op_f = bus.X ^ bus.Y;
      OP_SHL: begin
        op_f    = {bus.X[WIDTH-2:0], 1'b0};
        op_cout = bus.X[WIDTH-1];
      end
      OP_ASR: begin
        op_f    = {bus.X[WIDTH-1], bus.X[WIDTH-1:1]};
        op_cout = bus.X[0];
      end
      default: op_f = '0;
    endcase
  end

  // Results hold until the next completion; starting an operation does not clear them.
  always_comb begin
    f_d    = f_q;
    phi_d  = phi_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (accept && !mul_load) begin
      f_d    = op_f;
      phi_d  = '0;
      cout_d = op_cout;
      ovf_d  = op_ovf;
      zero_d = (op_f == '0);
    end else if (state_q == ST_MUL && mul_last) begin
      f_d    = mul_prod[WIDTH-1:0];
      phi_d  = mul_prod[2*WIDTH-1:WIDTH];
      cout_d = 1'b0;
      ovf_d  = |mul_prod[2*WIDTH-1:WIDTH];
      zero_d = (mul_prod[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q    <= '0;
      phi_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      f_q    <= f_d;
      phi_q  <= phi_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.F        = f_q;
  assign bus.P_hi     = phi_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;
  assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu at WIDTH=5 and WIDTH=8 against an arithmetic model.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] phi;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  res_t sb5[$];
  res_t sb8[$];
  res_t last5, last8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(5)) bus5 ();
  seq_alu_if #(.WIDTH(8)) bus8 ();

  seq_alu #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5.slave));
  seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t lit(input logic [7:0] f, input logic [7:0] phi,
                               input logic c, input logic v, input logic z);
    res_t r;
    r.f = f; r.phi = phi; r.cout = c; r.ovf = v; r.zero = z;
    return r;
  endfunction

  function automatic res_t model(input int w, input logic [2:0] op, input int x, input int y);
    res_t r;
    int m, half, sx, sy, sr, p;
    m    = 1 << w;
    half = 1 << (w - 1);
    sx   = (x >= half) ? x - m : x;
    sy   = (y >= half) ? y - m : y;
    r    = '0;
    case (op)
      3'd0: begin
        r.f    = 8'((x + y) % m);
        r.cout = (x + y) >= m;
        sr     = sx + sy;
        r.ovf  = (sr < -half) || (sr > half - 1);
      end
      3'd1: begin
        r.f    = 8'((x + m - y) % m);
        r.cout = x >= y;
        sr     = sx - sy;
        r.ovf  = (sr < -half) || (sr > half - 1);
      end
      3'd2: r.f = 8'(x & y);
      3'd3: r.f = 8'(x | y);
      3'd4: r.f = 8'(x ^ y);
      3'd5: begin
        r.f    = 8'((x * 2) % m);
        r.cout = ((x >> (w - 1)) & 1) != 0;
      end
      3'd6: begin
        r.f    = 8'((x >> 1) | (x & half));
        r.cout = (x & 1) != 0;
      end
      default: begin
        p     = x * y;
        r.f   = 8'(p % m);
        r.phi = 8'(p / m);
        r.ovf = (p / m) != 0;
      end
    endcase
    r.zero = (r.f == 8'd0);
    return r;
  endfunction

  task automatic drive(input int w, input logic st, input logic [2:0] s,
                       input logic [7:0] x, input logic [7:0] y);
    if (w == 5) begin
      bus5.start = st; bus5.S = s; bus5.X = x[4:0]; bus5.Y = y[4:0];
    end else begin
      bus8.start = st; bus8.S = s; bus8.X = x; bus8.Y = y;
    end
  endtask

  function automatic res_t get(input int w);
    res_t r;
    if (w == 5) begin
      r.f = {3'b000, bus5.F}; r.phi = {3'b000, bus5.P_hi};
      r.cout = bus5.Cout; r.ovf = bus5.Overflow; r.zero = bus5.Zero;
    end else begin
      r.f = bus8.F; r.phi = bus8.P_hi;
      r.cout = bus8.Cout; r.ovf = bus8.Overflow; r.zero = bus8.Zero;
    end
    return r;
  endfunction

  function automatic logic [1:0] get_hs(input int w);
    return (w == 5) ? {bus5.busy, bus5.done} : {bus8.busy, bus8.done};
  endfunction

  // poke_cyc > 0 raises start (S=ADD) in that cycle after the start edge; it must be ignored.
  task automatic run_op(input int w, input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat, input int poke_cyc,
                        input string tag, output res_t o);
    res_t e, got;
    int   cyc, busy_cyc;
    logic seen;
    cyc = 0; busy_cyc = 0; seen = 1'b0; o = '0;
    e = model(w, op, int'(x), int'(y));
    if (w == 5) sb5.push_back(e); else sb8.push_back(e);
    drive(w, 1'b1, op, x, y);
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (get_hs(w)[1]) busy_cyc++;
      if (op == OP_MUL && cyc == 2)
        chk({tag, "/hold"}, 32'(get(w).f), 32'((w == 5) ? last5.f : last8.f));
      if (get_hs(w)[0]) seen = 1'b1;
      drive(w, cyc == poke_cyc, (cyc == poke_cyc) ? OP_ADD : op, 8'($urandom), 8'($urandom));
    end
    chk({tag, "/done_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/busy_cycles"}, busy_cyc, exp_lat);
    if (seen) begin
      o = get(w);
      if (w == 5 && sb5.size() > 0) begin
        got = sb5.pop_front();
        chk({tag, "/result"}, 32'(o), 32'(got));
        last5 = got;
      end else if (w == 8 && sb8.size() > 0) begin
        got = sb8.pop_front();
        chk({tag, "/result"}, 32'(o), 32'(got));
        last8 = got;
      end else begin
        chk({tag, "/sb_nonempty"}, 32'd0, 32'd1);
      end
    end
    @(negedge clk);
    drive(w, 1'b0, op, x, y);
    chk({tag, "/idle_after"}, 32'(get_hs(w)), 32'd0);
  endtask

  initial begin
    res_t o;
    int   ndone, lat, poke;
    logic [2:0] rop;
    reset = 1'b1;
    last5 = '0; last8 = '0;
    drive(5, 1'b0, OP_ADD, 8'd0, 8'd0);
    drive(8, 1'b0, OP_ADD, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    chk("rst5_res", 32'(get(5)), 32'd0);
    chk("rst5_hs", 32'(get_hs(5)), 32'd0);
    chk("rst8_res", 32'(get(8)), 32'd0);
    chk("rst8_hs", 32'(get_hs(8)), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(5, OP_ADD, 8'h03, 8'h0A, 1, 0, "add", o);
    chk("add_lit", 32'(o), 32'(lit(8'h0D, 8'h00, 1'b0, 1'b0, 1'b0)));
    run_op(5, OP_SUB, 8'h10, 8'h02, 1, 0, "sub", o);
    chk("sub_lit", 32'(o), 32'(lit(8'h0E, 8'h00, 1'b1, 1'b1, 1'b0)));
    run_op(5, OP_ASR, 8'h10, 8'h00, 1, 0, "asr", o);
    chk("asr_lit", 32'(o), 32'(lit(8'h18, 8'h00, 1'b0, 1'b0, 1'b0)));
    run_op(5, OP_MUL, 8'h0B, 8'h04, 6, 3, "mul", o);
    chk("mul_lit", 32'(o), 32'(lit(8'h0C, 8'h01, 1'b0, 1'b1, 1'b0)));
    run_op(5, OP_ADD, 8'h1F, 8'h01, 1, 1, "add_wrap", o);
    chk("add_wrap_lit", 32'(o), 32'(lit(8'h00, 8'h00, 1'b1, 1'b0, 1'b1)));
    run_op(5, OP_AND, 8'h1A, 8'h0F, 1, 0, "and", o);
    run_op(5, OP_OR,  8'h1A, 8'h0F, 1, 0, "or", o);
    run_op(5, OP_XOR, 8'h1A, 8'h0F, 1, 0, "xor", o);
    chk("xor_lit", 32'(o), 32'(lit(8'h15, 8'h00, 1'b0, 1'b0, 1'b0)));
    run_op(5, OP_SHL, 8'h13, 8'h00, 1, 0, "shl", o);
    chk("shl_lit", 32'(o), 32'(lit(8'h06, 8'h00, 1'b1, 1'b0, 1'b0)));

    // Reset two cycles into a multiply: abort, everything cleared, no done.
    sb5.push_back(model(5, OP_MUL, 31, 31));
    drive(5, 1'b1, OP_MUL, 8'h1F, 8'h1F);
    @(negedge clk);
    drive(5, 1'b0, OP_MUL, 8'h1F, 8'h1F);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_res", 32'(get(5)), 32'd0);
    chk("rst_mid_hs", 32'(get_hs(5)), 32'd0);
    sb5.delete();
    last5 = '0; last8 = '0;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus5.done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_op(5, OP_ADD, 8'h05, 8'h06, 1, 0, "add_after_rst", o);
    chk("add_after_rst_lit", 32'(o), 32'(lit(8'h0B, 8'h00, 1'b0, 1'b0, 1'b0)));
    run_op(5, OP_MUL, 8'h1F, 8'h1F, 6, 0, "mul_max5", o);
    chk("mul_max5_lit", 32'(o), 32'(lit(8'h01, 8'h1E, 1'b0, 1'b1, 1'b0)));

    run_op(8, OP_MUL, 8'hFF, 8'hFF, 9, 4, "mul8", o);
    chk("mul8_lit", 32'(o), 32'(lit(8'h01, 8'hFE, 1'b0, 1'b1, 1'b0)));

    for (int i = 0; i < 1000; i++) begin
      rop  = 3'($urandom_range(0, 7));
      lat  = (rop == OP_MUL) ? 9 : 1;
      poke = $urandom_range(0, lat);
      run_op(8, rop, 8'($urandom), 8'($urandom), lat, poke, "rand8", o);
    end
    for (int i = 0; i < 100; i++) begin
      rop  = 3'($urandom_range(0, 7));
      lat  = (rop == OP_MUL) ? 6 : 1;
      run_op(5, rop, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)), lat, 0, "rand5", o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the team's combinational 5-bit ALU.
- Adds a start/busy/done handshake, registered results and flags, a wider 3-bit opcode space and a multi-cycle shift-add unsigned multiplier.
- Sits between the datapath register file and the result bus. One operation is in flight at a time.

Parameters:
- WIDTH, 5: operand and result width in bits (legal range 2..32).
- CNT_BITS, $clog2(WIDTH+1): width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- X  input  WIDTH  operand A, latched on accepted start.
- Y  input  WIDTH  operand B, latched on accepted start.
- S  input  3  opcode, latched on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- F  output  WIDTH  result; low half of the product for MUL.
- P_hi  output  WIDTH  high half of the product for MUL; 0 for other ops.
- Cout  output  1  carry / no-borrow / shifted-out bit.
- Overflow  output  1  signed overflow (ADD/SUB); P_hi != 0 for MUL.
- Zero  output  1  F == 0.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0, as do the operand, accumulator and counter registers.
  - Reset mid-MUL aborts the operation. No done pulse is produced.
- Opcodes:
  - 000 ADD: {Cout,F} = X+Y.
  - 001 SUB: F = X-Y (two's complement); Cout = (X >= Y) unsigned.
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL: F = X<<1; Cout = X[MSB].
  - 110 ASR: F = X>>>1 with sign fill; Cout = X[0].
  - 111 MUL: unsigned, {P_hi,F} = X*Y.
- Flag rules:
  - Overflow for ADD/SUB: operand sign bits vs result sign bit, standard two's-complement rule.
  - Logic ops and shifts: Overflow = 0.
  - Logic ops and MUL: Cout = 0.
  - Zero is evaluated on F only.
- State machine:
  - States are IDLE, MUL, DONE.
  - IDLE with start=1 and S != 111: compute at that edge, register F/flags, go to DONE.
  - IDLE with start=1 and S = 111: latch X and Y; clear the 2*WIDTH accumulator and counter; go to MUL.
  - MUL: each cycle, if multiplier LSB = 1, add the multiplicand into the accumulator upper half; shift right by 1; increment the counter.
  - MUL exit: after WIDTH iterations, register {P_hi,F}, Overflow and Zero; go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - done is high in the cycle after the start edge for single-cycle ops.
  - done is high WIDTH+1 cycles after the start edge for MUL.
- Handshake:
  - start while busy is ignored; operands are not re-latched.
  - start in the same cycle that DONE returns to IDLE is also ignored. Only IDLE samples start.
- Result hold: F, P_hi and flags keep the last completed result until the next completion or reset. They are not cleared at start.
- Operands are latched, so X, Y and S may change freely while busy.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - state encoding ST_IDLE, ST_MUL, ST_DONE;
  - a function for signed add/sub overflow.
- Sub-module seq_alu_mul (WIDTH param) holds the shift-add multiplier.
  - Interface: load, X, Y in; run, last out; product out.
  - seq_alu owns the FSM, the single-cycle ops, the flags and the output registers.

Test Plan (WIDTH=5):
- ADD, X=00011, Y=01010, start → next cycle done=1, F=01101, Cout=0, Overflow=0, Zero=0, P_hi=00000.
- SUB, X=10000, Y=00010 → F=01110, Cout=1, Overflow=1 (-16-2), Zero=0; ASR X=10000 → F=11000, Cout=0.
- MUL, X=01011, Y=00100:
  - busy is high for 6 cycles, with done in the 6th cycle after start.
  - Result: F=01100, P_hi=00001, Overflow=1, Cout=0.
  - Pulsing start=1 with S=000 mid-operation is ignored and does not change the result.
- ADD, X=11111, Y=00001 → F=00000, Cout=1, Zero=1, Overflow=0.
- MUL 11111*11111 → {P_hi,F}=11110_00001, Overflow=1. Assert reset 2 cycles after start → all outputs 0, busy=0, no done. A fresh ADD completes normally.
- Parameter sweep, WIDTH=8, MUL 255*255 → P_hi=0xFE, F=0x01, done 9 cycles after start; random ops checked against a behavioural model for 1000 transactions.
